hdlverifier_jtag_burst_ctrl: RTL and testbench

Burst sequencer in the tck domain that drives the addr/wdata/write/rdata port of the JTAG user-register bank.
- Accepts one command (read or write, start address, length) from the JTAG command decoder.
- Streams write words in through a valid/ready interface, or streams read words out through a valid/ready interface.
- Auto-increments the register address and accounts for the bank's 1-cycle registered read latency.

---
 rtl/hdlverifier_jtag_burst_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hdlverifier_jtag_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlverifier_jtag_burst_ctrl.sv
// JTAG user-register burst sequencer: one command drives a write or read burst with auto-increment.
// Optional stall-abort logic is built when HDLVERIFIER_JTAG_BURST_TIMEOUT_EN is defined.
module hdlverifier_jtag_burst_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_tck,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_write,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [DATA_W-1:0]   r_reg_wdata;
    logic                r_reg_write;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_done;
    logic                w_wr_hs;
    logic                w_rd_hs;
    logic                w_last;
    logic                w_timeout;

    assign w_wr_hs = (r_state == S_WRITE) && i_wr_valid;
    assign w_rd_hs = (r_state == S_RD_HOLD) && i_rd_ready;
    assign w_last  = (r_rem == '0);

`ifdef HDLVERIFIER_JTAG_BURST_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_timeout_err;
    logic               w_stall;

    // In WRITE/RD_HOLD every cycle is either a handshake or a stall, so
    // clearing on "not stalling" also covers handshakes and state entry.
    assign w_stall   = ((r_state == S_WRITE) && !i_wr_valid) ||
                       ((r_state == S_RD_HOLD) && !i_rd_ready);
    assign w_timeout = w_stall && (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge i_tck or posedge i_reset) begin
        if (i_reset) begin
            r_stall       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_stall <= (w_stall && !w_timeout) ? r_stall + STALL_W'(1) : '0;
            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if ((r_state == S_IDLE) && i_cmd_valid)
                r_timeout_err <= 1'b0;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign o_timeout_err    = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge i_tck or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_cmd_valid)
                    w_next = i_cmd_write ? S_WRITE : S_RD_ADDR;
            end
            S_WRITE: begin
                o_wr_ready = 1'b1;
                if (w_timeout || (w_wr_hs && w_last))
                    w_next = S_IDLE;
            end
            S_RD_ADDR: w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_RD_HOLD;
            S_RD_HOLD: begin
                if (w_rd_hs)
                    w_next = w_last ? S_IDLE : S_RD_ADDR;
                else if (w_timeout)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_addr is the next address to use; o_reg_addr shows the address of the
    // beat just written, or the address being read.
    always_ff @(posedge i_tck or posedge i_reset) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_rem       <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_write <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr     <= i_cmd_addr;
                        r_reg_addr <= i_cmd_addr;
                        r_rem      <= i_cmd_len;
                    end
                end
                S_WRITE: begin
                    if (w_wr_hs) begin
                        r_reg_wdata <= i_wr_data;
                        r_reg_addr  <= r_addr;
                        r_reg_write <= 1'b1;
                        r_addr      <= r_addr + ADDR_W'(1);
                        if (w_last)
                            r_done <= 1'b1;
                        else
                            r_rem <= r_rem - LEN_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    r_rd_data  <= i_reg_rdata;
                    r_rd_valid <= 1'b1;
                end
                S_RD_HOLD: begin
                    if (w_rd_hs) begin
                        r_rd_valid <= 1'b0;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_reg_addr <= r_addr + ADDR_W'(1);
                        if (w_last)
                            r_done <= 1'b1;
                        else
                            r_rem <= r_rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
            if (w_timeout) begin
                r_done     <= 1'b1;
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_write = r_reg_write;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_done      = r_done;

endmodule

// File: tb/tb_hdlverifier_jtag_burst_ctrl.sv
// Bench for hdlverifier_jtag_burst_ctrl: per-cycle comparison against a beat-level burst model,
// a command table, hand sequences (reset, backpressure, stall abort) and random bursts.
module tb_hdlverifier_jtag_burst_ctrl;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;
`ifdef HDLVERIFIER_JTAG_BURST_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
    localparam int BP_CYC = 12;
`else
    localparam bit TO_EN  = 1'b0;
    localparam int BP_CYC = 20;
`endif

    logic              tck = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_ready;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_write;
    logic [DATA_W-1:0] bank_rdata = '0;
    logic              busy, done, timeout_err;

    hdlverifier_jtag_burst_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_tck(tck), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata), .o_reg_write(reg_write),
        .i_reg_rdata(bank_rdata),
        .o_busy(busy), .o_done(done), .o_timeout_err(timeout_err)
    );

    always #5 tck = ~tck;

    // Register bank with 1-cycle registered read latency.
    always @(posedge tck) bank_rdata <= 32'h1000 + {27'd0, reg_addr};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_wbeats, n_rhs, n_done;

    // Beat-level model of the burst: mode 0 idle, 1 write, 2 read.
    int          m_mode, m_k, m_len, m_t0, m_s;
    logic [4:0]  m_start, m_raddr;
    logic [31:0] m_wdata, m_rdata;
    logic        m_wr, m_done, m_rvalid, m_terr;

    function automatic logic [4:0] wrap(input int a);
        return a[4:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_len = 0; m_t0 = 0; m_s = 0;
        m_start = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
        m_wr = 0; m_done = 0; m_rvalid = 0; m_terr = 0;
    endtask

    task automatic model_stall();
        m_s++;
        if (TO_EN && m_s == TIMEOUT) begin
            m_mode = 0; m_done = 1'b1; m_terr = 1'b1;
        end
    endtask

    task automatic model_step();
        m_wr = 1'b0; m_done = 1'b0;
        case (m_mode)
            0: if (cmd_valid) begin
                m_start = cmd_addr; m_len = int'(cmd_len); m_k = 0; m_t0 = cyc;
                m_raddr = cmd_addr; m_terr = 1'b0; m_s = 0;
                m_mode = cmd_write ? 1 : 2;
            end
            1: if (wr_valid) begin
                m_s = 0; m_wr = 1'b1; m_wdata = wr_data;
                m_raddr = wrap(int'(m_start) + m_k);
                if (m_k == m_len) begin m_done = 1'b1; m_mode = 0; end
                else m_k++;
            end else model_stall();
            default: if (m_rvalid) begin
                if (rd_ready) begin
                    m_s = 0;
                    m_raddr = wrap(int'(m_start) + m_k + 1);
                    if (m_k == m_len) begin m_done = 1'b1; m_mode = 0; end
                    else begin m_k++; m_t0 = cyc; end
                end else model_stall();
            end
        endcase
        m_rvalid = (m_mode == 2) && (cyc >= m_t0 + 2);
        if (m_mode == 2 && cyc == m_t0 + 2)
            m_rdata = 32'h1000 + {27'd0, wrap(int'(m_start) + m_k)};
    endtask

    task automatic compare_all();
        chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("wr_ready", 32'(wr_ready), 32'(m_mode == 1));
        chk("reg_write", 32'(reg_write), 32'(m_wr));
        chk("done", 32'(done), 32'(m_done));
        chk("reg_addr", 32'(reg_addr), 32'(m_raddr));
        chk("reg_wdata", reg_wdata, m_wdata);
        chk("rd_valid", 32'(rd_valid), 32'(m_rvalid));
        chk("rd_data", rd_data, m_rdata);
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic cycle();
        if (rd_valid && rd_ready) n_rhs++;
        @(posedge tck);
        model_step();
        #1;
        compare_all();
        if (reg_write) n_wbeats++;
        if (done) n_done++;
        cyc++;
    endtask

    task automatic run_burst(input logic wr, input logic [4:0] addr, input logic [7:0] len,
                             input int pct, input bit noise);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        wr_valid = ($urandom_range(99) < pct); wr_data = $urandom;
        rd_ready = ($urandom_range(99) < pct);
        cycle();
        n = 0;
        while (m_mode != 0 && n < 6000) begin
            cmd_valid = noise ? 1'($urandom_range(1)) : 1'b0;
            cmd_write = 1'($urandom_range(1)); cmd_addr = 5'($urandom); cmd_len = 8'($urandom);
            wr_valid = ($urandom_range(99) < pct); wr_data = $urandom;
            rd_ready = ($urandom_range(99) < pct);
            cycle();
            n++;
        end
        if (n >= 6000) begin
            checks++; errors++;
            $display("FAIL burst_bound: burst still running after %0d cycles", n);
        end
        cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] len;
        int         pct;
        int         exp_beats;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{1'b1, 5'd30, 8'd3,   100, 4,   5'd1};
        vecs[1] = '{1'b0, 5'd0,  8'd1,   100, 2,   5'd2};
        vecs[2] = '{1'b1, 5'd0,  8'd255, 100, 256, 5'd31};
        vecs[3] = '{1'b0, 5'd31, 8'd2,   100, 3,   5'd2};
        vecs[4] = '{1'b1, 5'd5,  8'd0,   100, 1,   5'd5};
        vecs[5] = '{1'b0, 5'd17, 8'd0,   70,  1,   5'd18};
        vecs[6] = '{1'b1, 5'd12, 8'd9,   60,  10,  5'd21};

        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        model_reset();
        repeat (2) @(posedge tck);
        #1 compare_all();
        #2 reset = 1'b0;

        // Command table, data streamed with the table's valid/ready density.
        for (int i = 0; i < 7; i++) begin
            n_wbeats = 0; n_rhs = 0; n_done = 0;
            run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].pct, 1'b0);
            chk($sformatf("vec%0d_beats", i), 32'(vecs[i].wr ? n_wbeats : n_rhs), 32'(vecs[i].exp_beats));
            chk($sformatf("vec%0d_other_beats", i), 32'(vecs[i].wr ? n_rhs : n_wbeats), 32'd0);
            chk($sformatf("vec%0d_done_count", i), 32'(n_done), 32'd1);
            chk($sformatf("vec%0d_final_addr", i), 32'(reg_addr), 32'(vecs[i].exp_addr));
        end

        // Reset during a write burst after two beats.
        n_done = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd2; cmd_len = 8'd3;
        wr_valid = 1'b1; wr_data = 32'hB0;
        cycle();
        cmd_valid = 1'b0;
        cycle(); wr_data = 32'hB1;
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        model_reset();
        wr_valid = 1'b0;
        @(posedge tck);
        #3 reset = 1'b0;
        cycle();
        chk("rst_no_done", 32'(n_done), 32'd0);
        n_wbeats = 0; n_done = 0;
        run_burst(1'b1, 5'd2, 8'd3, 100, 1'b0);
        chk("post_rst_beats", 32'(n_wbeats), 32'd4);
        chk("post_rst_done", 32'(n_done), 32'd1);

        // Read backpressure with commands offered while busy.
        n_done = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd7; cmd_len = 8'd0; rd_ready = 1'b0;
        cycle();
        cmd_valid = 1'b0;
        cycle(); cycle();
        for (int i = 0; i < BP_CYC; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd20; cmd_len = 8'd5;
            cycle();
            chk("bp_rd_data", rd_data, 32'h1007);
            chk("bp_rd_valid", 32'(rd_valid), 32'd1);
            chk("bp_reg_addr", 32'(reg_addr), 32'd7);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        cmd_valid = 1'b0; rd_ready = 1'b1;
        cycle();
        chk("bp_done", 32'(done), 32'd1);
        rd_ready = 1'b0;
        cycle();

        // Stall with rd_ready held low.
        n_done = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3; cmd_len = 8'd2; rd_ready = 1'b0;
        cycle();
        cmd_valid = 1'b0;
        n = 0;
`ifdef HDLVERIFIER_JTAG_BURST_TIMEOUT_EN
        while (busy && n < 100) begin cycle(); n++; end
        chk("to_cycles", 32'(n), 32'd18);
        chk("to_done_count", 32'(n_done), 32'd1);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_rd_valid", 32'(rd_valid), 32'd0);
        repeat (3) cycle();
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        run_burst(1'b1, 5'd9, 8'd0, 100, 1'b0);
        chk("to_err_clear", 32'(timeout_err), 32'd0);
`else
        while (n < 1000) begin cycle(); n++; end
        chk("nto_busy", 32'(busy), 32'd1);
        chk("nto_rd_valid", 32'(rd_valid), 32'd1);
        chk("nto_rd_data", rd_data, 32'h1003);
        chk("nto_err", 32'(timeout_err), 32'd0);
        chk("nto_done_count", 32'(n_done), 32'd0);
        rd_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin cycle(); n++; end
        chk("nto_finish_done", 32'(n_done), 32'd1);
        rd_ready = 1'b0;
        cycle();
`endif

        // Random bursts with random stalls and stray commands while busy.
        for (int i = 0; i < 40; i++) begin
            logic       rw;
            logic [7:0] rl;
            rw = 1'($urandom_range(1));
            rl = 8'($urandom_range(15));
            n_wbeats = 0; n_rhs = 0; n_done = 0;
            run_burst(rw, 5'($urandom), rl, int'($urandom_range(100, 50)), 1'b1);
            chk("rnd_done_count", 32'(n_done), 32'd1);
            if (!m_terr)
                chk("rnd_beats", 32'(rw ? n_wbeats : n_rhs), 32'(rl) + 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
